// File: rtl/host_fsm.sv
// Host-side sequencer: accepts one client request, sends a command byte (plus an optional
// payload byte) to the device, waits for a result or a timeout, then returns a one-cycle response.
module host_fsm #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] req_cmd,
  input  logic [DW-1:0] req_data,
  output logic          dev_cs,
  output logic [DW-1:0] dev_din,
  input  logic          dev_busy,
  input  logic          dev_drdy,
  input  logic [DW-1:0] dev_dout,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_WAIT = 3'd3,
    ST_RSP  = 3'd4
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t          state_q;
  logic [7:0]      cnt_q;
  logic [DW-1:0]   cmd_q;
  logic [DW-1:0]   data_q;
  logic            req_ready_q;
  logic            dev_cs_q;
  logic [DW-1:0]   dev_din_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_data_q;
  logic            rsp_err_q;

  logic            need_payload;
  logic            tx_mode;
  logic            wait_exit;

  // A payload byte follows the command for any non-zero opcode or when OP2 is set.
  assign need_payload = (cmd_q[DW-1:DW-4] != '0) || cmd_q[1];
  assign tx_mode      = cmd_q[0];
  assign wait_exit    = tx_mode ? dev_drdy : !dev_busy;

  // Outputs are registered and loaded together with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      req_ready_q <= 1'b1;
      dev_cs_q    <= 1'b0;
      dev_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      req_ready_q <= 1'b0;
      dev_cs_q    <= 1'b0;
      dev_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            cmd_q     <= req_cmd;
            data_q    <= req_data;
            dev_cs_q  <= 1'b1;
            dev_din_q <= req_cmd;
            state_q   <= ST_CMD;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_CMD: begin
          if (need_payload) begin
            dev_din_q <= data_q;
            state_q   <= ST_DATA;
          end else begin
            cnt_q   <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_DATA: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          // The exit condition takes priority over a timeout landing in the same cycle.
          if (wait_exit) begin
            rsp_data_q  <= tx_mode ? dev_dout : '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end else if (cnt_q == TO_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_RSP: begin
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign dev_cs    = dev_cs_q;
  assign dev_din   = dev_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_host_fsm.sv
// Randomized and directed bench for host_fsm; expectations come from a transaction-level
// model that derives the cycle timeline and response from the request and wait-phase inputs.
module tb_host_fsm;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_cmd;
  logic [DW-1:0] req_data;
  logic          dev_cs;
  logic [DW-1:0] dev_din;
  logic          dev_busy;
  logic          dev_drdy;
  logic [DW-1:0] dev_dout;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // wait-phase stimulus, indexed by cycle number inside the wait phase
  logic          w_busy [TO];
  logic          w_drdy [TO];
  logic [DW-1:0] w_dout [TO];

  // response values the DUT must be holding between transactions
  logic [DW-1:0] hold_data = '0;
  logic          hold_err  = 1'b0;

  host_fsm #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_data(req_data),
    .dev_cs(dev_cs), .dev_din(dev_din), .dev_busy(dev_busy), .dev_drdy(dev_drdy),
    .dev_dout(dev_dout), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic fill_idle_wait();
    for (int i = 0; i < TO; i++) begin
      w_busy[i] = 1'b1;
      w_drdy[i] = 1'b0;
      w_dout[i] = 8'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks += 6;
    if (req_ready !== 1'b1) $display("FAIL %s req_ready: got %b exp 1", name, req_ready); else n_pass++;
    if (dev_cs !== 1'b0) $display("FAIL %s dev_cs: got %b exp 0", name, dev_cs); else n_pass++;
    if (dev_din !== 8'h00) $display("FAIL %s dev_din: got %h exp 00", name, dev_din); else n_pass++;
    if (rsp_valid !== 1'b0) $display("FAIL %s rsp_valid: got %b exp 0", name, rsp_valid); else n_pass++;
    if (rsp_data !== 8'h00) $display("FAIL %s rsp_data: got %h exp 00", name, rsp_data); else n_pass++;
    if (rsp_err !== 1'b0) $display("FAIL %s rsp_err: got %b exp 0", name, rsp_err); else n_pass++;
  endtask

  // Entered just after a rising edge with the DUT idle; leaves just after the rising edge
  // that starts the idle cycle following the response.
  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] data, input bit hold,
                         input bit noise, input string name);
    bit            payload;
    bit            tx;
    int            first_wait;
    int            k;
    int            rsp_cycle;
    int            idx;
    logic [DW-1:0] e_data;
    logic          e_err;
    logic          e_cs;
    logic          e_rv;
    logic [DW-1:0] e_din;

    payload    = (cmd[7:4] != 4'd0) || cmd[1];
    tx         = cmd[0];
    first_wait = payload ? 3 : 2;
    k = -1;
    for (int i = 0; i < TO; i++)
      if (k < 0 && (tx ? w_drdy[i] : !w_busy[i])) k = i;
    rsp_cycle = first_wait + ((k < 0) ? TO : k + 1);
    e_data    = (k < 0 || !tx) ? 8'h00 : w_dout[k];
    e_err     = (k < 0);

    req_valid = 1'b1;
    req_cmd   = cmd;
    req_data  = data;
    @(negedge clk);
    n_checks += 5;
    if (req_ready !== 1'b1) $display("FAIL %s idle req_ready: got %b exp 1", name, req_ready); else n_pass++;
    if (dev_cs !== 1'b0 || dev_din !== 8'h00)
      $display("FAIL %s idle dev bus: got cs=%b din=%h exp cs=0 din=00", name, dev_cs, dev_din);
    else n_pass++;
    if (rsp_valid !== 1'b0) $display("FAIL %s idle rsp_valid: got %b exp 0", name, rsp_valid); else n_pass++;
    if (rsp_data !== hold_data) $display("FAIL %s idle rsp_data hold: got %h exp %h", name, rsp_data, hold_data); else n_pass++;
    if (rsp_err !== hold_err) $display("FAIL %s idle rsp_err hold: got %b exp %b", name, rsp_err, hold_err); else n_pass++;
    @(posedge clk); #1;

    for (int c = 1; c <= rsp_cycle; c++) begin
      req_valid = hold;
      req_cmd   = 8'($urandom);
      req_data  = 8'($urandom);
      if (c >= first_wait) begin
        idx      = c - first_wait;
        dev_busy = w_busy[idx];
        dev_drdy = w_drdy[idx];
        dev_dout = w_dout[idx];
      end else if (noise) begin
        dev_busy = 1'b0;
        dev_drdy = 1'b1;
        dev_dout = 8'hEE;
      end else begin
        dev_busy = 1'($urandom);
        dev_drdy = 1'($urandom);
        dev_dout = 8'($urandom);
      end
      e_cs  = (c == 1);
      e_din = (c == 1) ? cmd : ((payload && c == 2) ? data : 8'h00);
      e_rv  = (c == rsp_cycle);
      @(negedge clk);
      n_checks += 4;
      if (dev_cs !== e_cs) $display("FAIL %s c%0d dev_cs: got %b exp %b", name, c, dev_cs, e_cs); else n_pass++;
      if (dev_din !== e_din) $display("FAIL %s c%0d dev_din: got %h exp %h", name, c, dev_din, e_din); else n_pass++;
      if (rsp_valid !== e_rv) $display("FAIL %s c%0d rsp_valid: got %b exp %b", name, c, rsp_valid, e_rv); else n_pass++;
      if (req_ready !== 1'b0) $display("FAIL %s c%0d req_ready: got %b exp 0", name, c, req_ready); else n_pass++;
      n_checks += 2;
      if (e_rv) begin
        if (rsp_data !== e_data) $display("FAIL %s rsp_data: got %h exp %h", name, rsp_data, e_data); else n_pass++;
        if (rsp_err !== e_err) $display("FAIL %s rsp_err: got %b exp %b", name, rsp_err, e_err); else n_pass++;
      end else begin
        if (rsp_data !== hold_data) $display("FAIL %s c%0d rsp_data hold: got %h exp %h", name, c, rsp_data, hold_data); else n_pass++;
        if (rsp_err !== hold_err) $display("FAIL %s c%0d rsp_err hold: got %b exp %b", name, c, rsp_err, hold_err); else n_pass++;
      end
      @(posedge clk); #1;
    end

    hold_data = e_data;
    hold_err  = e_err;
    dev_busy  = 1'($urandom);
    dev_drdy  = 1'($urandom);
    dev_dout  = 8'($urandom);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req_valid = 1'b1;
    req_cmd   = 8'h81;
    req_data  = 8'h05;
    dev_busy  = 1'b0;
    dev_drdy  = 1'b1;
    dev_dout  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_compute_read();
    fill_idle_wait();
    w_drdy[1] = 1'b1;
    w_dout[1] = 8'h0C;
    run_txn(8'h81, 8'h05, 1'b0, 1'b0, "compute_read");
  endtask

  task automatic test_operand_load();
    fill_idle_wait();
    w_busy[1] = 1'b0;
    w_drdy[0] = 1'b1;
    run_txn(8'h02, 8'h07, 1'b0, 1'b0, "operand_load");
  endtask

  task automatic test_timeout();
    fill_idle_wait();
    run_txn(8'h01, 8'h33, 1'b0, 1'b0, "timeout");
  endtask

  task automatic test_tie();
    fill_idle_wait();
    w_drdy[TO-1] = 1'b1;
    w_dout[TO-1] = 8'hA5;
    run_txn(8'h01, 8'h00, 1'b0, 1'b0, "tie_tx");
    fill_idle_wait();
    w_busy[TO-1] = 1'b0;
    run_txn(8'h10, 8'h44, 1'b0, 1'b0, "tie_notx");
  endtask

  task automatic test_spurious();
    fill_idle_wait();
    w_drdy[2] = 1'b1;
    w_dout[2] = 8'h3C;
    w_drdy[3] = 1'b1;
    run_txn(8'h91, 8'h12, 1'b0, 1'b1, "spurious_payload");
    fill_idle_wait();
    w_drdy[0] = 1'b1;
    w_dout[0] = 8'hC3;
    run_txn(8'h01, 8'h00, 1'b0, 1'b1, "spurious_cmd");
  endtask

  task automatic test_back_to_back();
    fill_idle_wait();
    w_drdy[0] = 1'b1;
    w_dout[0] = 8'h61;
    run_txn(8'h41, 8'h22, 1'b1, 1'b0, "b2b_first");
    fill_idle_wait();
    w_busy[2] = 1'b0;
    run_txn(8'h30, 8'h99, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 1'b1;
    req_cmd   = 8'h01;
    req_data  = 8'h00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    dev_drdy  = 1'b0;
    dev_busy  = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1 check_reset_outputs("reset_mid_immediate");
    repeat (2) begin
      dev_drdy = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset_mid_held");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    hold_data = '0;
    hold_err  = 1'b0;
    fill_idle_wait();
    w_drdy[3] = 1'b1;
    w_dout[3] = 8'h7E;
    run_txn(8'hC1, 8'h0F, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int         mode;
    int         k;
    for (int t = 0; t < 40; t++) begin
      cmd  = 8'($urandom);
      mode = int'($urandom_range(0, 3));
      k    = (mode == 0) ? -1 : ((mode == 1) ? TO - 1 : int'($urandom_range(0, TO - 2)));
      for (int i = 0; i < TO; i++) begin
        w_dout[i] = 8'($urandom);
        if (cmd[0]) begin
          w_busy[i] = 1'($urandom);
          w_drdy[i] = (i < k || k < 0) ? 1'b0 : ((i == k) ? 1'b1 : 1'($urandom));
        end else begin
          w_drdy[i] = 1'($urandom);
          w_busy[i] = (i < k || k < 0) ? 1'b1 : ((i == k) ? 1'b0 : 1'($urandom));
        end
      end
      run_txn(cmd, 8'($urandom), (t != 39) && ($urandom_range(0, 3) == 0),
              1'($urandom), $sformatf("rand%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_compute_read();
    test_operand_load();
    test_timeout();
    test_tie();
    test_spurious();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
